// File: rtl/softmax_div_sequencer.sv
// Softmax normaliser: buffers N exponents, sums them, and issues one (exp<<FRAC)/sum division per element.
// Latency: ISSUE -> out_valid is DW+2 cycles when sum != 0, and 1 cycle when sum == 0; one element every DW+3 cycles.
// Backpressure: out_ready low holds OUT (data/last/valid stable) and no new division starts; in_ready is high only in LOAD.
module softmax_div_sequencer #(
    parameter int N    = 8,
    parameter int DW   = 32,
    parameter int EW   = 16,
    parameter int FRAC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          div_start,
    output logic [DW-1:0] div_dividend,
    output logic [DW-1:0] div_divisor,
    input  logic [DW-1:0] div_quotient,
    input  logic          div_done,
    output logic          div_rst_n
);

    localparam int IW = $clog2(N);
    localparam int SW = EW + IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [EW-1:0]   r_buf [N];
    logic [IW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [SW-1:0]   r_sum;
    logic [DW-1:0]   r_out_data;
    logic            r_clr_n;
    logic            w_sum_zero;
    logic            w_in_fire;
    logic            w_out_fire;

    assign w_sum_zero = (r_sum == '0);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Operands come straight from buffered state, so they cannot move while the divider works.
    assign div_dividend = DW'({r_buf[r_idx], {FRAC{1'b0}}});
    assign div_divisor  = DW'(r_sum);
    assign out_data     = r_out_data;
    // The divider is held in reset by the system reset or by the one-cycle post-result clear.
    assign div_rst_n    = rst & r_clr_n;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_cnt == LAST_IDX)) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = w_sum_zero ? S_OUT : S_WAIT;
            S_WAIT:  if (div_done) w_state_nxt = S_OUT;
            S_OUT: begin
                if (w_out_fire) begin
                    w_state_nxt = (r_idx == LAST_IDX) ? S_LOAD : S_ISSUE;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Handshake and divider-start outputs decoded from the current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        div_start = 1'b0;
        case (r_state)
            S_LOAD:  in_ready  = 1'b1;
            S_ISSUE: div_start = !w_sum_zero;
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = (r_idx == LAST_IDX);
            end
            default: ;
        endcase
    end

    // Datapath: buffer fill, running sum, element index, result capture and divider clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_out_data <= '0;
            r_clr_n    <= 1'b1;
        end else begin
            // The clear is a single-cycle pulse; released before the next start is sampled.
            r_clr_n <= 1'b1;
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_cnt] <= in_data;
                        r_sum        <= r_sum + {{IW{1'b0}}, in_data};
                        if (r_cnt == LAST_IDX) begin
                            r_cnt <= '0;
                            r_idx <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // An all-zero vector yields zero probabilities without touching the divider.
                    if (w_sum_zero) r_out_data <= '0;
                end
                S_WAIT: begin
                    if (div_done) begin
                        r_out_data <= div_quotient;
                        r_clr_n    <= 1'b0;
                    end
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            r_cnt <= '0;
                            r_sum <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
